// File: rtl/unflatten_streamer_pkg.sv
// Shared constants and FSM state type for the unflatten streamer.
package unflatten_streamer_pkg;

    localparam int unsigned FEATURE_MAP_RESOLUTION = 16;
    localparam int unsigned FEATURE_MAP_ADDRWIDE   = 8;
    localparam int unsigned DENSE_WEIGHTS_ADDRWIDE = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } unflatten_state_t;

endpackage

// File: rtl/unflatten_beat_mux.sv
// Combinational slice selector: picks the OUT_D channels of one pixel from the
// buffered flat vector, or zeros when disabled.
module unflatten_beat_mux
    import unflatten_streamer_pkg::*;
#(
    parameter int unsigned OUT_D           = 8,
    parameter int unsigned FLATTEN_IN_SIZE = 40
) (
    input  logic [FEATURE_MAP_RESOLUTION-1:0] vec  [0:FLATTEN_IN_SIZE-1],
    input  logic [FEATURE_MAP_ADDRWIDE-1:0]   pixel,
    input  logic                              en,
    output logic [FEATURE_MAP_RESOLUTION-1:0] beat [0:OUT_D-1]
);

    localparam int unsigned DW = DENSE_WEIGHTS_ADDRWIDE;
    localparam int unsigned IW = (FLATTEN_IN_SIZE > 1) ? $clog2(FLATTEN_IN_SIZE) : 1;

    // Element index p*OUT_D + c, computed at full dense-address width.
    function automatic logic [DW-1:0] elem_idx(input logic [FEATURE_MAP_ADDRWIDE-1:0] p,
                                               input int unsigned c);
        return DW'(p) * DW'(OUT_D) + DW'(c);
    endfunction

    always_comb begin
        for (int unsigned c = 0; c < OUT_D; c++) begin
            beat[c] = '0;
            if (en && (elem_idx(pixel, c) < DW'(FLATTEN_IN_SIZE))) begin
                beat[c] = vec[IW'(elem_idx(pixel, c))];
            end
        end
    end

endmodule

// File: rtl/unflatten_streamer.sv
// Buffers one flattened vector and replays it as one OUT_D-channel beat per pixel.
// Optional macro UNFLATTEN_LAST_EN adds feature_out_last_o on the final beat.
module unflatten_streamer
    import unflatten_streamer_pkg::*;
#(
    parameter int unsigned OUT_D           = 8,
    parameter int unsigned OUT_H           = 5,
    parameter int unsigned OUT_W           = 1,
    parameter int unsigned OUT_WXH         = OUT_H * OUT_W,
    parameter int unsigned FLATTEN_IN_SIZE = OUT_WXH * OUT_D
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flatten_valid_i,
    input  logic [FEATURE_MAP_RESOLUTION-1:0] flatten_data_i [0:FLATTEN_IN_SIZE-1],
    output logic                              flatten_ready_o,
    output logic                              feature_out_valid_o,
    output logic [FEATURE_MAP_RESOLUTION-1:0] feature_out_data_o [0:OUT_D-1],
    output logic [FEATURE_MAP_ADDRWIDE-1:0]   feature_out_addr_o,
    input  logic                              feature_out_ready_i,
`ifdef UNFLATTEN_LAST_EN
    output logic                              feature_out_last_o,
`endif
    output logic                              done_o
);

    localparam int unsigned AW = FEATURE_MAP_ADDRWIDE;
    localparam logic [AW-1:0] LAST_PIX = AW'(OUT_WXH - 1);

    if (OUT_WXH > (32'd1 << FEATURE_MAP_ADDRWIDE)) begin : g_addr_chk
        $error("OUT_WXH exceeds the pixel address range");
    end
    if ((FLATTEN_IN_SIZE - 1) >= (32'd1 << DENSE_WEIGHTS_ADDRWIDE)) begin : g_idx_chk
        $error("FLATTEN_IN_SIZE exceeds the slice index range");
    end

    unflatten_state_t state_q, state_n;
    logic [AW-1:0] cnt_q, cnt_n;
    logic [FEATURE_MAP_RESOLUTION-1:0] buf_q [0:FLATTEN_IN_SIZE-1];
    logic [FEATURE_MAP_RESOLUTION-1:0] buf_n [0:FLATTEN_IN_SIZE-1];
    logic [FEATURE_MAP_RESOLUTION-1:0] beat_n [0:OUT_D-1];
    logic ready_n, valid_n, done_n, last_n, last_q;
    logic [AW-1:0] addr_n;

    // Next state plus next registered outputs, derived from the upcoming state.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        buf_n   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (flatten_valid_i && flatten_ready_o) begin
                    buf_n   = flatten_data_i;
                    cnt_n   = '0;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (feature_out_valid_o && feature_out_ready_i) begin
                    if (cnt_q == LAST_PIX) state_n = DONE;
                    else                   cnt_n   = cnt_q + AW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
        valid_n = (state_n == STREAM);
        done_n  = (state_n == DONE);
        addr_n  = valid_n ? cnt_n : '0;
        last_n  = valid_n && (cnt_n == LAST_PIX);
    end

    unflatten_beat_mux #(
        .OUT_D           (OUT_D),
        .FLATTEN_IN_SIZE (FLATTEN_IN_SIZE)
    ) u_beat_mux (
        .vec   (buf_n),
        .pixel (cnt_n),
        .en    (valid_n),
        .beat  (beat_n)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            flatten_ready_o     <= 1'b0;
            feature_out_valid_o <= 1'b0;
            feature_out_addr_o  <= '0;
            feature_out_data_o  <= '{default: '0};
            done_o              <= 1'b0;
            last_q              <= 1'b0;
        end else begin
            state_q             <= state_n;
            cnt_q               <= cnt_n;
            flatten_ready_o     <= ready_n;
            feature_out_valid_o <= valid_n;
            feature_out_addr_o  <= addr_n;
            feature_out_data_o  <= beat_n;
            done_o              <= done_n;
            last_q              <= last_n;
        end
    end

    // Vector buffer keeps its contents through reset.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_n;
    end

`ifdef UNFLATTEN_LAST_EN
    assign feature_out_last_o = last_q;
`else
    logic unused_last;
    assign unused_last = last_q;
`endif

endmodule

// File: tb/tb_unflatten_streamer.sv
// Self-checking bench: queue-based beat model plus directed literal checks.
module tb_unflatten_streamer;
    import unflatten_streamer_pkg::*;

    localparam int D   = 8;
    localparam int WXH = 5;
    localparam int N   = D * WXH;
    localparam int D1  = 4;
    localparam int RES = FEATURE_MAP_RESOLUTION;

    typedef struct packed {
        logic [7:0]              addr;
        logic [D-1:0][RES-1:0]   d;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic fv, fready, ovalid, ordy, done;
    logic [RES-1:0] fdata [0:N-1];
    logic [RES-1:0] odata [0:D-1];
    logic [FEATURE_MAP_ADDRWIDE-1:0] oaddr;
`ifdef UNFLATTEN_LAST_EN
    logic olast;
    logic olast1;
`endif

    logic fv1, fready1, ovalid1, ordy1, done1;
    logic [RES-1:0] fdata1 [0:D1-1];
    logic [RES-1:0] odata1 [0:D1-1];
    logic [FEATURE_MAP_ADDRWIDE-1:0] oaddr1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unflatten_streamer dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flatten_valid_i     (fv),
        .flatten_data_i      (fdata),
        .flatten_ready_o     (fready),
        .feature_out_valid_o (ovalid),
        .feature_out_data_o  (odata),
        .feature_out_addr_o  (oaddr),
        .feature_out_ready_i (ordy),
`ifdef UNFLATTEN_LAST_EN
        .feature_out_last_o  (olast),
`endif
        .done_o              (done)
    );

    unflatten_streamer #(.OUT_D(D1), .OUT_H(1), .OUT_W(1)) dut1 (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flatten_valid_i     (fv1),
        .flatten_data_i      (fdata1),
        .flatten_ready_o     (fready1),
        .feature_out_valid_o (ovalid1),
        .feature_out_data_o  (odata1),
        .feature_out_addr_o  (oaddr1),
        .feature_out_ready_i (ordy1),
`ifdef UNFLATTEN_LAST_EN
        .feature_out_last_o  (olast1),
`endif
        .done_o              (done1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending beats; a vector is pushed on handshake, popped on transfer.
    beat_t q[$];
    logic  m_ready = 1'b0;
    logic  m_done  = 1'b0;

    always @(negedge clk) begin : model
        beat_t b;
        logic  hs, done_nx;
        b = '0;
        if (q.size() != 0) b = q[0];
        chk("m_valid", int'(ovalid), int'(q.size() != 0));
        chk("m_addr", int'(oaddr), int'(b.addr));
        for (int c = 0; c < D; c++) chk("m_data", int'(odata[c]), int'(b.d[c]));
        chk("m_ready", int'(fready), int'(m_ready));
        chk("m_done", int'(done), int'(m_done));
`ifdef UNFLATTEN_LAST_EN
        chk("m_last", int'(olast), int'(q.size() != 0 && int'(b.addr) == WXH - 1));
`endif
        if (!rst_n) begin
            q.delete();
            m_ready = 1'b0;
            m_done  = 1'b0;
        end else begin
            hs      = m_ready && fv;
            done_nx = 1'b0;
            if (q.size() != 0 && ordy) begin
                void'(q.pop_front());
                if (q.size() == 0) done_nx = 1'b1;
            end
            if (hs) begin
                for (int p = 0; p < WXH; p++) begin
                    b.addr = 8'(p);
                    for (int c = 0; c < D; c++) b.d[c] = fdata[p*D + c];
                    q.push_back(b);
                end
            end
            m_done  = done_nx;
            m_ready = (q.size() == 0) && !done_nx;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base);
        for (int k = 0; k < N; k++) fdata[k] = RES'(base + k);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!fready && n < 20) begin
            step();
            n++;
        end
        chk(name, int'(fready), 1);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; fv = 1'b0; ordy = 1'b1; load(0);
        fv1 = 1'b0; ordy1 = 1'b1;
        for (int k = 0; k < D1; k++) fdata1[k] = RES'(50 + k);
        step(); step();
        chk("rst_ready", int'(fready), 0);
        chk("rst_valid", int'(ovalid), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", int'(fready), 1);

        // Full-rate stream of the k pattern
        fv = 1'b1; step(); fv = 1'b0;
        for (int p = 0; p < WXH; p++) begin
            chk("t1_valid", int'(ovalid), 1);
            chk("t1_addr", int'(oaddr), p);
            if (p == 2) for (int c = 0; c < D; c++) chk("t1_beat2", int'(odata[c]), 16 + c);
            step();
        end
        chk("t1_done", int'(done), 1);
        chk("t1_ready_lo", int'(fready), 0);
        step();
        chk("t1_done_off", int'(done), 0);
        chk("t1_ready_back", int'(fready), 1);

        // Backpressure at beat 1 and on the final beat
        fv = 1'b1; step(); fv = 1'b0;
        step();
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_valid", int'(ovalid), 1);
            chk("t2_hold_addr", int'(oaddr), 1);
            chk("t2_hold_d0", int'(odata[0]), 8);
            chk("t2_hold_d7", int'(odata[7]), 15);
            step();
        end
        ordy = 1'b1;
        chk("t2_still1", int'(oaddr), 1);
        step();
        chk("t2_addr2", int'(oaddr), 2);
        step(); step();
        chk("t2_addr4", int'(oaddr), 4);
        ordy = 1'b0;
        step(); step();
        chk("t2_stall4", int'(oaddr), 4);
`ifdef UNFLATTEN_LAST_EN
        chk("t2_last", int'(olast), 1);
`endif
        ordy = 1'b1;
        step();
        chk("t2_done", int'(done), 1);
        wait_ready("t2_ready");

        // New vector presented while busy is ignored until IDLE
        fv = 1'b1; step(); load(100);
        step(); step(); step();
        chk("t3_addr3", int'(oaddr), 3);
        chk("t3_old_d0", int'(odata[0]), 24);
        step(); step();
        chk("t3_done", int'(done), 1);
        step();
        chk("t3_ready", int'(fready), 1);
        step(); fv = 1'b0;
        chk("t3_new_d0", int'(odata[0]), 100);
        chk("t3_new_d7", int'(odata[7]), 107);

        // Reset in the middle of the stream at beat 3
        step(); step(); step();
        chk("t4_addr3", int'(oaddr), 3);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("t4_valid", int'(ovalid), 0);
        chk("t4_addr", int'(oaddr), 0);
        chk("t4_d3", int'(odata[3]), 0);
        chk("t4_done", int'(done), 0);
        step();
        chk("t4_ready", int'(fready), 1);
        chk("t4_no_done", int'(done), 0);
        step(); step();

        // Single-beat configuration
        chk("t5_ready", int'(fready1), 1);
        fv1 = 1'b1; step(); fv1 = 1'b0;
        chk("t5_valid", int'(ovalid1), 1);
        chk("t5_addr", int'(oaddr1), 0);
        for (int c = 0; c < D1; c++) chk("t5_data", int'(odata1[c]), 50 + c);
`ifdef UNFLATTEN_LAST_EN
        chk("t5_last", int'(olast1), 1);
`endif
        step();
        chk("t5_done", int'(done1), 1);
        chk("t5_valid_off", int'(ovalid1), 0);
        step();
        chk("t5_done_off", int'(done1), 0);
        chk("t5_ready_back", int'(fready1), 1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unflatten_streamer.md
Name: unflatten_streamer

Overview:
- Inverse of the flatten stage.
- Accepts one flattened feature vector of FLATTEN_IN_SIZE elements in a single valid/ready handshake and buffers it internally.
- Replays the buffered vector pixel by pixel: one beat per pixel, each beat carrying OUT_D channels, with a pixel address on a valid/ready stream.
- Sits between a dense/flatten-domain producer and a feature-map consumer, such as a conv or pooling input port or a flatten block.

Parameters:
- OUT_D, 8, channels per output beat.
- OUT_H, 5, feature-map height.
- OUT_W, 1, feature-map width.
- OUT_WXH, OUT_H*OUT_W, pixels (beats) per vector.
- FLATTEN_IN_SIZE, OUT_WXH*OUT_D, elements in the input vector.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- flatten_valid_i  in  1  input vector valid.
- flatten_data_i  in  FEATURE_MAP_RESOLUTION x [0:FLATTEN_IN_SIZE-1]  flattened vector.
- flatten_ready_o  out  1  block can accept a vector.
- feature_out_valid_o  out  1  beat valid.
- feature_out_data_o  out  FEATURE_MAP_RESOLUTION x [0:OUT_D-1]  channel values of the current pixel.
- feature_out_addr_o  out  FEATURE_MAP_ADDRWIDE  pixel index 0..OUT_WXH-1.
- feature_out_ready_i  in  1  consumer accepts the beat.
- done_o  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values: state=IDLE; flatten_ready_o=0 during reset; feature_out_valid_o=0; feature_out_addr_o=0; feature_out_data_o all 0; done_o=0. The internal buffer is not cleared.
- Element order: beat p, channel c = flatten_data_i[p*OUT_D + c]. This matches the channel-interleaved layout written by the flatten stage.
- IDLE:
  - flatten_ready_o=1; all stream outputs 0.
  - When flatten_valid_i && flatten_ready_o: capture the whole vector into the buffer, clear the pixel counter, go to STREAM.
- STREAM:
  - flatten_ready_o=0; feature_out_valid_o=1.
  - addr = pixel counter; data = buffer slice for that pixel.
  - A beat transfers when feature_out_valid_o && feature_out_ready_i.
  - On transfer with counter < OUT_WXH-1: increment counter, stay in STREAM.
  - On transfer with counter == OUT_WXH-1: go to DONE.
  - Without a transfer: valid, addr and data are held stable (no retraction, no change).
- DONE: done_o=1 for exactly one cycle; valid=0, ready=0; go to IDLE.
- Latency and throughput:
  - First beat is valid the cycle after the input handshake.
  - With ready held high, OUT_WXH beats are emitted on consecutive cycles.
  - One vector takes OUT_WXH+2 cycles, handshake to next flatten_ready_o.
- Data outputs: zero whenever feature_out_valid_o=0.
- Input side: flatten_valid_i while not ready is ignored. The producer must hold its data until the handshake.
- Simultaneous events: flatten_valid_i asserted during STREAM or DONE has no effect on the buffer.
- Reset mid-operation: immediately returns to IDLE with the reset values above. The partial vector is discarded and done_o is not pulsed.
- Degenerate size: OUT_WXH=1 gives a single beat with addr 0, then DONE.
- Width rules:
  - Pixel counter is FEATURE_MAP_ADDRWIDE bits.
  - Elaboration assertion: OUT_WXH <= 2**FEATURE_MAP_ADDRWIDE.
  - Slice index computation is done at DENSE_WEIGHTS_ADDRWIDE width, with no truncation for FLATTEN_IN_SIZE-1.
- default state branch returns to IDLE.

Optional Feature:
- Macro: UNFLATTEN_LAST_EN.
- With the macro defined:
  - Adds output port feature_out_last_o (1 bit).
  - It is high together with feature_out_valid_o only on the beat with addr == OUT_WXH-1.
  - Reset value 0; held stable under backpressure like the data.
- Without the macro: the port is absent and behaviour is otherwise identical.

Decomposition:
- pkg_parameters holds:
  - FEATURE_MAP_RESOLUTION, FEATURE_MAP_ADDRWIDE and DENSE_WEIGHTS_ADDRWIDE, which are existing constants.
  - A new typedef enum unflatten_state_t {IDLE, STREAM, DONE}.
- One sub-module is natural: unflatten_beat_mux. It is purely combinational: buffer plus pixel index in, OUT_D-element slice out, zero when its enable is low.
- FSM, counter and buffer stay in unflatten_streamer.

Test Plan:
- Defaults (D=8, H=5, W=1) with flatten_data_i[k]=k and feature_out_ready_i held 1:
  - 5 beats on consecutive cycles with addr 0..4.
  - Beat 2 data = {16..23}.
  - done_o pulses one cycle after beat 4; flatten_ready_o returns 2 cycles after the last beat.
- Backpressure: ready low for 3 cycles at beat 1 -> addr=1, data {8..15} and valid held stable all 3 cycles; beat 1 transfers once ready rises.
- Input while busy: new vector flatten_data_i[k]=100+k presented during STREAM -> ignored; the current stream keeps the k-pattern; the new vector is only accepted after returning to IDLE.
- Reset at beat 3: rst_ni low for 1 cycle -> next cycle valid=0, addr=0, data=0, done_o never pulses, flatten_ready_o=1.
- OUT_H=1, OUT_W=1, OUT_D=4: single beat, addr 0, data {k0..k3}, done_o the next cycle.
- With UNFLATTEN_LAST_EN: feature_out_last_o=1 only on the addr=4 beat, including while that beat is stalled by backpressure.
